fifo_uart_tx: RTL and testbench

- Read-side consumer of the 8-bit, 4-deep `fifo`.
- Pops one byte whenever the FIFO is non-empty and the line is idle, then serialises it on a UART-style line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the `fifo` output port and the chip-level serial pin. It is the draining end of the push/pop buffer.

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/fifo_uart_baud_cnt.sv | 35 +++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam logic        IDLE_LEVEL     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick is high on the last count.
module fifo_uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // tick is registered from the next count so it lines up with cnt_q == LAST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises them as 8N1 frames on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int unsigned      BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic [15:0]       frames_d;
    logic              tx_d;
    logic              pop_d;
    logic              busy_d;
    logic              baud_clr;
    logic              baud_tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q;
    logic              parity_d;
`endif

    // Bit timing restarts at LOAD so START gets a full period
    assign baud_clr = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

    fifo_uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        frames_d  = frames_sent;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = POP;
            end
            POP: state_d = LOAD;
            LOAD: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_data;
`endif
                state_d   = START;
            end
            START: begin
                if (baud_tick) state_d = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) state_d = STOP;
            end
`endif
            // fifo_empty is only looked at here and in IDLE
            STOP: begin
                if (baud_tick) begin
                    frames_d = frames_sent + 16'd1;
                    state_d  = fifo_empty ? IDLE : POP;
                end
            end
            default: state_d = IDLE;
        endcase

        pop_d  = (state_d == POP);
        busy_d = (state_d != IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx          <= IDLE_LEVEL;
            fifo_pop    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx          <= tx_d;
            fifo_pop    <= pop_d;
            busy        <= busy_d;
            frames_sent <= frames_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx with a 4-deep FIFO and a frame-level reference model.
module tb_fifo_uart_tx;

    localparam int unsigned N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned NSYM = 11;
`else
    localparam int unsigned NSYM = 10;
`endif
    localparam int unsigned FRAME_CYC = NSYM * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_pop;
    logic        tx;
    logic        busy;
    logic [15:0] frames_sent;

    logic        push_en = 1'b0;
    logic [7:0]  push_data = 8'h00;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int unsigned accepted = 0;

    // Bench FIFO: 4 entries, one-cycle read latency after the pop strobe
    logic [7:0]  fmem [4];
    int unsigned fwr = 0;
    int unsigned frd = 0;
    int unsigned fcount = 0;

    // Reference model state: bytes in push order, and per-cycle {tx,busy,pop,last} expectations
    logic [7:0]  mq[$];
    logic [3:0]  sched[$];
    logic [15:0] frames_exp = 16'h0000;

    fifo_uart_tx #(
        .CLKS_PER_BIT(N),
        .DATA_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = (fcount == 0);

    always @(posedge clk) begin
        if (push_en && fcount < 4) begin
            fmem[fwr] <= push_data;
            fwr       <= (fwr + 1) % 4;
        end
        if (fifo_pop && fcount > 0) begin
            fifo_data <= fmem[frd];
            frd       <= (frd + 1) % 4;
        end
        fcount <= fcount + ((push_en && fcount < 4) ? 1 : 0) - ((fifo_pop && fcount > 0) ? 1 : 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_frame(input logic [7:0] b);
        logic [10:0] sym;
`ifdef FIFO_UART_TX_PARITY_EN
        sym = {1'b1, ^b, b, 1'b0};
`else
        sym = {1'b0, 1'b1, b, 1'b0};
`endif
        sched.push_back(4'b1110);
        sched.push_back(4'b1100);
        for (int s = 0; s < int'(NSYM); s++) begin
            for (int c = 0; c < int'(N); c++) begin
                sched.push_back({sym[s], 1'b1, 1'b0, (s == int'(NSYM) - 1) && (c == int'(N) - 1)});
            end
        end
    endtask

    // Compare DUT against the model every cycle, then decide what the next cycle holds
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sched.delete();
                frames_exp = 16'h0000;
            end
            e = (sched.size() > 0) ? sched.pop_front() : 4'b1000;
            check("model_tx", 32'(tx), 32'(e[3]));
            check("model_busy", 32'(busy), 32'(e[2]));
            check("model_pop", 32'(fifo_pop), 32'(e[1]));
            check("model_frames", 32'(frames_sent), 32'(frames_exp));
            if (fifo_pop && fifo_empty) check("pop_while_empty", 32'(fifo_pop), 32'(0));
            if (e[0]) frames_exp = frames_exp + 16'd1;
            if (reset && sched.size() == 0 && !fifo_empty && mq.size() > 0) add_frame(mq.pop_front());
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #2;
        if (fcount < 4) begin
            push_en   = 1'b1;
            push_data = b;
            mq.push_back(b);
            accepted++;
        end
        @(posedge clk);
        #2;
        push_en = 1'b0;
    endtask

    task automatic wait_pop(input string name, output int lat, output int unsigned at);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        at  = 0;
        while (lat < 400) begin
            @(negedge clk);
            if (fifo_pop) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            lat++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: no fifo_pop within 400 cycles", name);
        end
    endtask

    task automatic wait_frames(input string name, input logic [15:0] target, input int bound);
        int n;
        n = 0;
        while (frames_sent !== target && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(frames_sent), 32'(target));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int unsigned p1;
        int unsigned p2;
        logic [10:0] a5_exp;
        logic [7:0]  burst [4];
        int          n;

`ifdef FIFO_UART_TX_PARITY_EN
        a5_exp = 11'h54A;
`else
        a5_exp = 11'h34A;
`endif
        burst[0] = 8'h03;
        burst[1] = 8'h01;
        burst[2] = 8'h17;
        burst[3] = 8'h55;

        // Reset held for 3 cycles
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pop", 32'(fifo_pop), 32'(0));
        check("rst_frames", 32'(frames_sent), 32'(0));

        // Single byte 0xA5 with bit-accurate timing
        push(8'hA5);
        wait_pop("a5_pop", lat, p1);
        check("pop_latency", 32'(lat), 32'(1));
        @(negedge clk);
        check("a5_gap_load", 32'(tx), 32'(1));
        @(negedge clk);
        check("a5_start_edge", 32'(tx), 32'(0));
        for (int i = 0; i < int'(NSYM); i++) begin
            repeat ((i == 0) ? 1 : int'(N)) @(negedge clk);
            check($sformatf("a5_sym%0d", i), 32'(tx), 32'(a5_exp[i]));
        end
        repeat (2) @(negedge clk);
        check("a5_last_stop_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("a5_end_busy", 32'(busy), 32'(0));
        check("a5_frames", 32'(frames_sent), 32'(1));

        // Burst of four bytes pushed on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            push_en   = 1'b1;
            push_data = burst[i];
            mq.push_back(burst[i]);
        end
        @(posedge clk);
        #2 push_en = 1'b0;
        wait_frames("burst_frames", 16'd5, 4 * int'(FRAME_CYC) + 100);
        check("burst_fifo_empty", 32'(fifo_empty), 32'(1));

        // Second byte pushed mid-frame is popped right after the first stop bit
        push(8'h10);
        wait_pop("mid_pop1", lat, p1);
        repeat (10) @(negedge clk);
        push(8'h23);
        wait_pop("mid_pop2", lat, p2);
        check("mid_pop_spacing", p2 - p1, FRAME_CYC + 2);
        wait_frames("mid_frames", 16'd7, 2 * int'(FRAME_CYC) + 100);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity bit sits just before the stop bit
        push(8'h07);
        wait_pop("par07_pop", lat, p1);
        repeat (3 + 4 * 9) @(negedge clk);
        check("par07_bit", 32'(tx), 32'(1));
        repeat (6) @(negedge clk);
        check("par07_len_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("par07_len_idle", 32'(busy), 32'(0));
        push(8'h03);
        wait_pop("par03_pop", lat, p1);
        repeat (3 + 4 * 9) @(negedge clk);
        check("par03_bit", 32'(tx), 32'(0));
        wait_frames("par_frames", 16'd9, int'(FRAME_CYC) + 50);
`endif

        // Reset pulse in the middle of DATA
        push(8'h00);
        wait_pop("rst_mid_pop", lat, p1);
        repeat (10) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'(0));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx), 32'(1));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_frames", 32'(frames_sent), 32'(0));
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'(0));

        // Random traffic
        accepted = 0;
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(0, 50)) @(posedge clk);
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
        end
        n = 0;
        while (!(fifo_empty && !busy && sched.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", 32'(busy), 32'(0));
        check("drain_frames", 32'(frames_sent), accepted);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
